// File: rtl/round_control_if.sv
// Signal bundle between the round control unit and its surroundings:
// round inputs from the datapath/player side, counter/register controls
// and round status going back out.
interface round_control_if;
    logic       start;
    logic       play;
    logic       match;
    logic       last;
    logic       cnt_clr_n;
    logic       cnt_en;
    logic       reg_en;
    logic       done;
    logic       win;
    logic       timeout;
    logic [3:0] db_state;

    // Drives the round inputs and observes the controls/status.
    modport master (
        output start, play, match, last,
        input  cnt_clr_n, cnt_en, reg_en, done, win, timeout, db_state
    );

    // The control unit itself.
    modport slave (
        input  start, play, match, last,
        output cnt_clr_n, cnt_en, reg_en, done, win, timeout, db_state
    );
endinterface

// File: rtl/round_control.sv
// Moore control unit for one play round: sequences the position counter
// and play register, times out a slow player and reports win/lose/timeout.
// Every output is decoded from the state register alone.
module round_control #(
    parameter int TIMEOUT = 5000
) (
    input  logic                  clk,
    input  logic                  clr,
    round_control_if.slave        bus
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE  = 4'h0,
        PREP  = 4'h1,
        WAIT  = 4'h2,
        STORE = 4'h3,
        CHECK = 4'h4,
        NEXT  = 4'h5,
        WIN   = 4'hA,
        LOSE  = 4'hE,
        TOUT  = 4'hF
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [TW-1:0]   timer_reg;
    logic [TW-1:0]   timer_next;

    // State and timer registers; clr forces IDLE at once, independent of clk.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= IDLE;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
        end
    end

    // Timer counts WAIT cycles and is zero everywhere else; it stops at its
    // last value because WAIT is always left on that cycle, so it never wraps.
    always_comb begin
        timer_next = '0;
        if (state_reg == WAIT && timer_reg != TIMER_LAST) begin
            timer_next = timer_reg + TW'(1);
        end
    end

    // Next-state logic; play takes priority over timer expiry in WAIT.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (bus.start) state_next = PREP;
            PREP:  state_next = WAIT;
            WAIT: begin
                if (bus.play) begin
                    state_next = STORE;
                end else if (timer_reg == TIMER_LAST) begin
                    state_next = TOUT;
                end
            end
            STORE: state_next = CHECK;
            CHECK: begin
                if (!bus.match) begin
                    state_next = LOSE;
                end else if (bus.last) begin
                    state_next = WIN;
                end else begin
                    state_next = NEXT;
                end
            end
            NEXT:  state_next = WAIT;
            WIN, LOSE, TOUT: if (bus.start) state_next = PREP;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the state register only.
    always_comb begin
        bus.cnt_clr_n = 1'b1;
        bus.cnt_en    = 1'b0;
        bus.reg_en    = 1'b0;
        bus.done      = 1'b0;
        bus.win       = 1'b0;
        bus.timeout   = 1'b0;
        bus.db_state  = state_reg;
        case (state_reg)
            IDLE, PREP: bus.cnt_clr_n = 1'b0;
            STORE:      bus.reg_en    = 1'b1;
            NEXT:       bus.cnt_en    = 1'b1;
            WIN: begin
                bus.done = 1'b1;
                bus.win  = 1'b1;
            end
            LOSE:       bus.done = 1'b1;
            TOUT: begin
                bus.done    = 1'b1;
                bus.timeout = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_round_control.sv
// Scoreboard bench for round_control: stimulus pushes the expected state
// sequence (with the expected dwell of the preceding state), a monitor pops
// on every observed state change and checks the decoded outputs each cycle.
module tb_round_control;
    localparam int TIMEOUT = 8;

    localparam logic [3:0] S_IDLE  = 4'h0;
    localparam logic [3:0] S_PREP  = 4'h1;
    localparam logic [3:0] S_WAIT  = 4'h2;
    localparam logic [3:0] S_STORE = 4'h3;
    localparam logic [3:0] S_CHECK = 4'h4;
    localparam logic [3:0] S_NEXT  = 4'h5;
    localparam logic [3:0] S_WIN   = 4'hA;
    localparam logic [3:0] S_LOSE  = 4'hE;
    localparam logic [3:0] S_TOUT  = 4'hF;

    logic clk = 1'b0;
    logic clr;

    round_control_if bus ();

    round_control #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        int         dwell;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_change = 0;
    logic [3:0] last_st = 4'h0;
    int   n_cnt_en = 0;
    int   n_reg_en = 0;

    // Expected {cnt_clr_n, cnt_en, reg_en, done, win, timeout} per state.
    function automatic logic [5:0] exp_out(input logic [3:0] s);
        case (s)
            S_IDLE, S_PREP: return 6'b000000;
            S_WAIT, S_CHECK: return 6'b100000;
            S_STORE: return 6'b101000;
            S_NEXT:  return 6'b110000;
            S_WIN:   return 6'b100110;
            S_LOSE:  return 6'b100100;
            S_TOUT:  return 6'b100101;
            default: return 6'b111111;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input int dwell);
        exp_t e;
        e.st = st;
        e.dwell = dwell;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int n = 0;
        while (bus.db_state !== s && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(bus.db_state), 32'(s));
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_play(input logic m, input logic l);
        bus.match = m;
        bus.last  = l;
        bus.play  = 1'b1;
        tick();
        bus.play  = 1'b0;
    endtask

    // Monitor: output decode every cycle, scoreboard pop on each state change.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            check("outputs", 32'({bus.cnt_clr_n, bus.cnt_en, bus.reg_en,
                                  bus.done, bus.win, bus.timeout}),
                  32'(exp_out(bus.db_state)));
            if (bus.cnt_en === 1'b1) n_cnt_en++;
            if (bus.reg_en === 1'b1) n_reg_en++;
            if (bus.db_state !== last_st) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_transition: got %0h, expected to stay in %0h",
                             bus.db_state, last_st);
                end else begin
                    e = q.pop_front();
                    check("state_seq", 32'(bus.db_state), 32'(e.st));
                    if (e.dwell >= 0) begin
                        check("dwell", 32'(cyc - last_change), 32'(e.dwell));
                    end
                end
                last_st = bus.db_state;
                last_change = cyc;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clr       = 1'b1;
        bus.start = 1'b0;
        bus.play  = 1'b0;
        bus.match = 1'b0;
        bus.last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(bus.db_state), 32'(S_IDLE));
        check("reset_cnt_clr_n", 32'(bus.cnt_clr_n), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        clr = 1'b0;
        tick();

        // Play pulses in IDLE are ignored.
        repeat (3) do_play(1'b1, 1'b1);
        tick();
        check("idle_ignores_play", 32'(bus.db_state), 32'(S_IDLE));

        // Win over 4 positions.
        n_cnt_en = 0;
        n_reg_en = 0;
        push(S_PREP, -1);
        push(S_WAIT, 1);
        do_start();
        for (int i = 0; i < 4; i++) begin
            wait_state(S_WAIT, 10, "win_wait");
            push(S_STORE, 1);
            push(S_CHECK, 1);
            if (i == 3) begin
                push(S_WIN, 1);
            end else begin
                push(S_NEXT, 1);
                push(S_WAIT, 1);
            end
            do_play(1'b1, i == 3);
        end
        wait_state(S_WIN, 10, "win_reach");
        repeat (6) tick();
        check("win_hold_state", 32'(bus.db_state), 32'(S_WIN));
        check("win_hold_win", 32'(bus.win), 32'd1);
        check("win_hold_done", 32'(bus.done), 32'd1);
        check("win_cnt_en_pulses", 32'(n_cnt_en), 32'd3);
        check("win_reg_en_pulses", 32'(n_reg_en), 32'd4);

        // Restart from WIN into a lose round.
        n_cnt_en = 0;
        push(S_PREP, -1);
        push(S_WAIT, 1);
        push(S_STORE, 1);
        push(S_CHECK, 1);
        push(S_NEXT, 1);
        push(S_WAIT, 1);
        push(S_STORE, 1);
        push(S_CHECK, 1);
        push(S_LOSE, 1);
        do_start();
        wait_state(S_WAIT, 10, "lose_wait1");
        do_play(1'b1, 1'b0);
        wait_state(S_WAIT, 10, "lose_wait2");
        do_play(1'b0, 1'b0);
        wait_state(S_LOSE, 10, "lose_reach");
        repeat (3) tick();
        check("lose_done", 32'(bus.done), 32'd1);
        check("lose_win", 32'(bus.win), 32'd0);
        check("lose_timeout", 32'(bus.timeout), 32'd0);
        check("lose_cnt_en_pulses", 32'(n_cnt_en), 32'd1);

        // Timeout without any play: WAIT lasts exactly TIMEOUT cycles.
        push(S_PREP, -1);
        push(S_WAIT, 1);
        push(S_TOUT, TIMEOUT);
        do_start();
        wait_state(S_TOUT, 30, "tout_reach");
        tick();
        check("tout_timeout", 32'(bus.timeout), 32'd1);
        check("tout_done", 32'(bus.done), 32'd1);

        // Timeout after one NEXT: timer restarts from zero.
        push(S_PREP, -1);
        push(S_WAIT, 1);
        push(S_STORE, 1);
        push(S_CHECK, 1);
        push(S_NEXT, 1);
        push(S_WAIT, 1);
        push(S_TOUT, TIMEOUT);
        do_start();
        wait_state(S_WAIT, 10, "tout2_wait");
        do_play(1'b1, 1'b0);
        wait_state(S_WAIT, 10, "tout2_wait_again");
        wait_state(S_TOUT, 30, "tout2_reach");

        // Play on the cycle the timer reads TIMEOUT-1: play wins.
        push(S_PREP, -1);
        push(S_WAIT, 1);
        push(S_STORE, TIMEOUT);
        push(S_CHECK, 1);
        push(S_WIN, 1);
        do_start();
        wait_state(S_WAIT, 10, "coinc_wait");
        repeat (TIMEOUT - 1) tick();
        do_play(1'b1, 1'b1);
        check("coinc_store", 32'(bus.db_state), 32'(S_STORE));
        wait_state(S_WIN, 10, "coinc_win");

        // Asynchronous clr in the middle of WAIT.
        push(S_PREP, -1);
        push(S_WAIT, 1);
        push(S_IDLE, -1);
        do_start();
        wait_state(S_WAIT, 10, "clr_wait");
        repeat (3) tick();
        #1 clr = 1'b1;
        #1;
        check("clr_async_state", 32'(bus.db_state), 32'(S_IDLE));
        check("clr_async_cnt_clr_n", 32'(bus.cnt_clr_n), 32'd0);
        check("clr_async_done", 32'(bus.done), 32'd0);
        #1 clr = 1'b0;
        tick();

        // Resume from IDLE after clr.
        push(S_PREP, -1);
        push(S_WAIT, 1);
        push(S_STORE, 1);
        push(S_CHECK, 1);
        push(S_LOSE, 1);
        do_start();
        wait_state(S_WAIT, 10, "post_clr_wait");
        do_play(1'b0, 1'b0);
        wait_state(S_LOSE, 10, "post_clr_lose");
        repeat (3) tick();
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/round_control.md
Name: round_control

Overview:
- Moore control unit for one play round of the lab datapath.
- Sits directly downstream of the position counter: it consumes the counter's terminal condition and the datapath compare result.
- It drives the counter's clear and count-enable inputs and the play-register enable.
- It has an internal response-timeout timer and reports win, lose or timeout to the top-level.

Parameters:
- TIMEOUT, default 5000: clock cycles allowed in WAIT before timeout. Minimum 2.
- TW, default $clog2(TIMEOUT): timer width. Derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous reset, active-high.
- start  input  1  begin or restart a round. Level, sampled on clk.
- play  input  1  one-cycle pulse per player move. Already debounced and edge-detected upstream.
- match  input  1  datapath compare of stored play against expected value. Valid in CHECK.
- last  input  1  counter is at its final position. Must be an unqualified terminal compare; the counter carry is gated by enable and reads 0 in CHECK.
- cnt_clr_n  output  1  to counter clear, active-low.
- cnt_en  output  1  to counter enp and ent.
- reg_en  output  1  load the play register.
- done  output  1  round finished.
- win  output  1  round won.
- timeout  output  1  round ended by timeout.
- db_state  output  4  state code, for debug display.

Behaviour:
- Moore FSM: one state register and a TW-bit timer, both reset asynchronously by clr.
- All outputs are decoded from the state only. No input reaches an output combinationally.
- State codes (db_state): IDLE 0x0, PREP 0x1, WAIT 0x2, STORE 0x3, CHECK 0x4, NEXT 0x5, WIN 0xA, LOSE 0xE, TOUT 0xF.
- Output decode (all others 0, cnt_clr_n=1):
  - IDLE: cnt_clr_n=0.
  - PREP: cnt_clr_n=0.
  - STORE: reg_en=1.
  - NEXT: cnt_en=1.
  - WIN: done=1, win=1.
  - LOSE: done=1.
  - TOUT: done=1, timeout=1.
- Reset values: state IDLE, timer 0, cnt_clr_n=0, all other outputs 0, db_state=0x0.
- clr asserted mid-round forces IDLE immediately, without waiting for a clock edge. Release resumes from IDLE.
- Transitions:
  - IDLE: start=1 -> PREP; else stay.
  - PREP: -> WAIT unconditionally.
  - WAIT: play=1 -> STORE. Else, if timer==TIMEOUT-1 -> TOUT. Else stay.
  - STORE: -> CHECK.
  - CHECK: match=0 -> LOSE. match=1 and last=1 -> WIN. match=1 and last=0 -> NEXT.
  - NEXT: -> WAIT.
  - WIN, LOSE, TOUT: start=1 -> PREP; else hold, keeping outputs stable.
- Timer:
  - Cleared to 0 on every cycle the state is not WAIT.
  - Increments by 1 each cycle in WAIT.
  - Each WAIT visit therefore lasts at most TIMEOUT cycles. The timer never wraps.
- Simultaneous events:
  - play and timer expiry in the same cycle: play wins, next state STORE.
  - start is ignored in PREP..NEXT.
  - play is ignored outside WAIT.
- Counter side effects:
  - The counter is held clear while in IDLE and PREP.
  - It advances exactly once per NEXT visit, so a win over K positions produces K-1 cnt_en pulses.
- Latency from a play pulse: STORE is the next cycle, CHECK the one after, and the result state (WIN/LOSE/NEXT) the cycle after that.

Test Plan:
- Reset:
  - Stimulus: drive the FSM to WAIT, then pulse clr between clock edges.
  - Required: db_state=0x0, cnt_clr_n=0 and done=0 before the next clk edge.
  - Required: start=1 after clr release reaches PREP, then WAIT.
- Win, 4 positions, TIMEOUT=8:
  - Stimulus: start, then 4 play pulses with match=1, last=1 on the 4th.
  - Required: exactly 3 cnt_en pulses and 4 reg_en pulses.
  - Required: end in done=1, win=1, db_state=0xA, held until start.
- Lose:
  - Stimulus: match=1 on the 1st play, match=0 on the 2nd.
  - Required: LOSE (0xE), done=1, win=0, timeout=0, exactly 1 cnt_en pulse.
- Timeout, TIMEOUT=8:
  - Stimulus: enter WAIT and never play.
  - Required: WAIT lasts exactly 8 cycles, then TOUT (0xF) with timeout=1 and done=1.
  - Stimulus: repeat after one NEXT. Required: the timer restarts from 0 and again allows 8 cycles.
- Coincidence and restart:
  - Stimulus: play on the cycle timer==7.
  - Required: next state STORE, not TOUT.
  - Stimulus: from WIN, assert start=1.
  - Required: PREP with cnt_clr_n=0, then WAIT with the timer at 0.
  - Stimulus: play pulses while in IDLE. Required: ignored.
